mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter for the shared data memory. The CPU data path (requester 0) and a second bus master such as a loader or debug port (requester 1) share one memory through it. It grants ownership round-robin, caps how many back-to-back accesses an owner may issue while the other side waits, and returns read data and a valid strobe to the issuing requester. It sits between the requesters and the `memory` and `port_memory` address decode.

## Interface
- BUS_SIZE, 32: data width.
- ADDR_SIZE, 8: word address width.
- MAX_HOLD, 16: max consecutive accepted accesses per owner while the other requester waits; legal range 1..255.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  access request; held high for back-to-back accesses.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_SIZE  word address.
- wdata0 / wdata1  in  BUS_SIZE  write data.
- gnt0 / gnt1  out  1  registered ownership grant.
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse.
- rdata0 / rdata1  out  BUS_SIZE  equal to mem_rdata; meaningful only while the matching rvalid is high.
- mem_en  out  1  access strobe to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_wdata  out  BUS_SIZE  memory write data.
- mem_rdata  in  BUS_SIZE  memory read data; synchronous read, valid the cycle after a read strobe.
- owner  out  1  last/current owner (0 or 1).

## Operation
- States:
  - IDLE: no grant.
  - OWN0: gnt0=1.
  - OWN1: gnt1=1.
- gnt0 and gnt1 are decoded from the state register. They are never high together.
- Accepted access: a cycle in OWNx with reqx=1.
  - The mem_* outputs are combinationally muxed from requester x in that cycle: mem_en=1, mem_we=wex, mem_addr=addrx, mem_wdata=wdatax.
  - In all other cycles every mem_* output is 0.
- IDLE transitions:
  - Only one req high: go to that requester's OWN state.
  - Both high: grant the requester that is not `owner` (round-robin pointer).
  - Neither high: stay in IDLE.
- OWNx transitions:
  - reqx=0: go to OWNy if reqy=1, else IDLE.
  - Hold expiry: reqx=1 and reqy=1 and hold_cnt==MAX_HOLD-1 → OWNy. The access accepted in that cycle completes normally.
  - Otherwise stay in OWNx.
- hold_cnt (8 bits):
  - Increments on each accepted access while the other req is high.
  - Clears on every state change and in any cycle the other req is low.
  - Never wraps, because expiry happens first.
- owner updates on entry to OWN0/OWN1 and keeps its value in IDLE.
- rvalidx is registered: it is set in the cycle after an accepted read by x and is high for exactly one cycle. It is not affected by a state change in that cycle.

## Timing
- Reset values: state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, owner=1 (so requester 0 wins the first contended grant), hold_cnt=0, all mem_* outputs=0.
- Grant latency:
  - req rises in cycle N while IDLE → gnt in cycle N+1.
  - First access in N+1 if req is still high.
- Read latency: access accepted in cycle M → rvalid and valid rdata in M+1.
- Throughput: one access per cycle while owned. Ownership switches with no bubble cycle when the other requester is waiting.
- Owner drops req in cycle N: no access in N. The new state takes effect in N+1.
- Requester handshake rule: a requester may change we/addr/wdata every cycle. Inputs are sampled only in cycles where its gnt is high.
- Async reset mid-operation:
  - Outputs clear immediately.
  - A pending rvalid is dropped.
  - A write in flight in the reset cycle is not guaranteed.
- Simultaneous reqx drop and hold expiry: treated as a reqx drop; go to OWNy.
- MAX_HOLD=1: ownership alternates on every access under contention.

## Test plan
- Reset: hold rst=0 with req0=req1=1 → all outputs 0. Release rst → gnt0=1 one cycle later, gnt1=0, owner=0.
- Single read: memory[0x10]=0xDEADBEEF; req1=1, we1=0, addr1=0x10 at cycle 0 → gnt1 and mem_en=1, mem_addr=0x10 at cycle 1. rvalid1=1 with rdata1=0xDEADBEEF at cycle 2, one cycle wide. rvalid0 stays 0.
- Write/read-back across requesters: req0 writes 0x12345678 to 0x20 and then drops. req1 then reads 0x20 → rdata1=0x12345678 with rvalid1.
- Fairness (MAX_HOLD=4): both reqs held high continuously → accesses alternate as exactly 4 by requester 0, then 4 by requester 1, repeating, with no idle cycles. gnt is never high on both.
- Round-robin from IDLE: req0 owns, drops, and IDLE is reached. Then req0 and req1 rise together → gnt1 granted first.
- Async reset mid-read: rst pulled low in the cycle of an accepted read by requester 0 → rvalid0 never asserts. After release, the state is IDLE and the next grant follows the reset rules.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared data memory.
// slave is the arbiter's view; master is the requesters-plus-memory side.
interface mem_arbiter_if #(
    parameter int BUS_SIZE  = 32,
    parameter int ADDR_SIZE = 8
);
    logic                 req0;
    logic                 req1;
    logic                 we0;
    logic                 we1;
    logic [ADDR_SIZE-1:0] addr0;
    logic [ADDR_SIZE-1:0] addr1;
    logic [BUS_SIZE-1:0]  wdata0;
    logic [BUS_SIZE-1:0]  wdata1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rvalid0;
    logic                 rvalid1;
    logic [BUS_SIZE-1:0]  rdata0;
    logic [BUS_SIZE-1:0]  rdata1;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [BUS_SIZE-1:0]  mem_wdata;
    logic [BUS_SIZE-1:0]  mem_rdata;
    logic                 owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one synchronous-read memory,
// with a cap on back-to-back accesses by one owner while the other waits.
//
// state | meaning
// IDLE  | no grant
// OWN0  | requester 0 owns the memory (gnt0)
// OWN1  | requester 1 owns the memory (gnt1)
module mem_arbiter #(
    parameter int BUS_SIZE  = 32,
    parameter int ADDR_SIZE = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic                 rvalid0_q, rvalid0_d;
    logic                 rvalid1_q, rvalid1_d;
    logic                 acc0, acc1;
    logic [ADDR_SIZE-1:0] addr_mux;
    logic [BUS_SIZE-1:0]  wdata_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            hold_cnt_q <= 8'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    always_comb begin
        acc0    = (state_q == OWN0) && bus.req0;
        acc1    = (state_q == OWN1) && bus.req1;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) state_d = owner_q ? OWN0 : OWN1;
                else if (bus.req0)        state_d = OWN0;
                else if (bus.req1)        state_d = OWN1;
            end
            OWN0: begin
                if (!bus.req0)                                state_d = bus.req1 ? OWN1 : IDLE;
                else if (bus.req1 && hold_cnt_q == HOLD_LAST) state_d = OWN1;
            end
            OWN1: begin
                if (!bus.req1)                                state_d = bus.req0 ? OWN0 : IDLE;
                else if (bus.req0 && hold_cnt_q == HOLD_LAST) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        owner_d = owner_q;
        if (state_d == OWN0) owner_d = 1'b0;
        if (state_d == OWN1) owner_d = 1'b1;

        // Only counts while the other side is actually waiting; any gap resets it.
        if (state_d != state_q)                           hold_cnt_d = 8'd0;
        else if ((acc0 && bus.req1) || (acc1 && bus.req0)) hold_cnt_d = hold_cnt_q + 8'd1;
        else                                              hold_cnt_d = 8'd0;

        rvalid0_d = acc0 && !bus.we0;
        rvalid1_d = acc1 && !bus.we1;
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        if (acc0) begin
            bus.mem_en = 1'b1;
            bus.mem_we = bus.we0;
            addr_mux   = bus.addr0;
            wdata_mux  = bus.wdata0;
        end else if (acc1) begin
            bus.mem_en = 1'b1;
            bus.mem_we = bus.we1;
            addr_mux   = bus.addr1;
            wdata_mux  = bus.wdata1;
        end
        bus.mem_addr  = addr_mux;
        bus.mem_wdata = wdata_mux;
    end

    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.owner   = owner_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = bus.mem_rdata;
    assign bus.rdata1  = bus.mem_rdata;
endmodule
